// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC generation, in-order memory requests with
// credit control, prefetch FIFO and redirect flush. Optional macro: FETCH_ALIGN_CHECK_EN.
module fetch_unit #(
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter int          DEPTH           = 4,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instruction,
   output logic [31:0] instr_pc,
   output logic        fetch_fault
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   logic [31:0]   fetch_pc_reg, fetch_pc_next;
   logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
   logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
   logic [CW-1:0] count_reg, count_next;
   logic [CW-1:0] outstanding_reg, outstanding_next;
   logic [CW-1:0] discard_reg, discard_next;
   logic [TW-1:0] tag_wr_reg, tag_wr_next;
   logic [TW-1:0] tag_rd_reg, tag_rd_next;

   logic [31:0] pc_mem   [DEPTH];
   logic [31:0] word_mem [DEPTH];
   logic [31:0] tag_mem  [MAX_OUTSTANDING];

   logic fault;
   logic credit_ok;
   logic accept;
   logic push;
   logic pop;

`ifdef FETCH_ALIGN_CHECK_EN
   logic fault_reg, fault_next;

   always_comb begin
      fault_next = fault_reg;
      if (redirect_valid)
         fault_next = (redirect_pc[1:0] != 2'b00);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         fault_reg <= 1'b0;
      else
         fault_reg <= fault_next;
   end

   assign fault = fault_reg;
`else
   assign fault = 1'b0;
`endif

   assign fetch_fault = fault;

   // Buffered plus in-flight words never exceed FIFO capacity, so responses always fit.
   assign credit_ok      = (int'(count_reg) + int'(outstanding_reg)) < DEPTH;
   assign imem_req_valid = !rst && !redirect_valid && !fault && credit_ok &&
                           (int'(outstanding_reg) < MAX_OUTSTANDING);
   assign imem_req_addr  = fetch_pc_reg;
   assign accept         = imem_req_valid && imem_req_ready;

   assign instr_valid = (count_reg != '0) && !fault;
   assign instruction = instr_valid ? word_mem[rd_ptr_reg] : 32'h0;
   assign instr_pc    = instr_valid ? pc_mem[rd_ptr_reg]   : 32'h0;

   assign pop  = instr_valid && instr_ready && !redirect_valid;
   assign push = imem_rsp_valid && !redirect_valid && (discard_reg == '0);

   always_comb begin
      fetch_pc_next    = fetch_pc_reg;
      wr_ptr_next      = wr_ptr_reg;
      rd_ptr_next      = rd_ptr_reg;
      count_next       = count_reg;
      discard_next     = discard_reg;
      tag_wr_next      = tag_wr_reg;
      tag_rd_next      = tag_rd_reg;
      outstanding_next = outstanding_reg + CW'(accept) - CW'(imem_rsp_valid);

      if (accept) begin
         fetch_pc_next = fetch_pc_reg + 32'd4;
         tag_wr_next   = (tag_wr_reg == TW'(MAX_OUTSTANDING - 1)) ? '0 : tag_wr_reg + 1'b1;
      end
      // Tags retire with every response, stale or not, so pairing stays in order.
      if (imem_rsp_valid)
         tag_rd_next = (tag_rd_reg == TW'(MAX_OUTSTANDING - 1)) ? '0 : tag_rd_reg + 1'b1;

      if (redirect_valid) begin
         fetch_pc_next = redirect_pc & 32'hFFFF_FFFC;
         rd_ptr_next   = wr_ptr_reg;
         count_next    = '0;
         discard_next  = outstanding_reg - CW'(imem_rsp_valid);
      end else begin
         if (imem_rsp_valid && (discard_reg != '0))
            discard_next = discard_reg - 1'b1;
         if (push)
            wr_ptr_next = wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_next = rd_ptr_reg + 1'b1;
         count_next = count_reg + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_reg    <= RESET_PC & 32'hFFFF_FFFC;
         wr_ptr_reg      <= '0;
         rd_ptr_reg      <= '0;
         count_reg       <= '0;
         outstanding_reg <= '0;
         discard_reg     <= '0;
         tag_wr_reg      <= '0;
         tag_rd_reg      <= '0;
      end else begin
         fetch_pc_reg    <= fetch_pc_next;
         wr_ptr_reg      <= wr_ptr_next;
         rd_ptr_reg      <= rd_ptr_next;
         count_reg       <= count_next;
         outstanding_reg <= outstanding_next;
         discard_reg     <= discard_next;
         tag_wr_reg      <= tag_wr_next;
         tag_rd_reg      <= tag_rd_next;
      end
   end

   // Storage arrays carry no reset; occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (accept)
         tag_mem[tag_wr_reg] <= fetch_pc_reg;
      if (push) begin
         pc_mem[wr_ptr_reg]   <= tag_mem[tag_rd_reg];
         word_mem[wr_ptr_reg] <= imem_rsp_data;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory model with optional response hold,
// hand-computed expectations for streaming, back-pressure, redirects and alignment.
module tb_fetch_unit;

   logic        clk;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instruction;
   logic [31:0] instr_pc;
   logic        fetch_fault;

   int          n_cmp = 0;
   int          n_err = 0;
   logic        hold;
   logic [31:0] pq [$];

   fetch_unit #(
      .RESET_PC        (32'h0000_0000),
      .DEPTH           (4),
      .MAX_OUTSTANDING (2)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instruction    (instruction),
      .instr_pc       (instr_pc),
      .fetch_fault    (fetch_fault)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: memory answers the oldest pending request (unless held), inputs are
   // applied at the falling edge, and accepted requests are queued for the next cycle.
   task automatic cyc(input logic rr, input logic rv, input logic [31:0] rp, input logic ir);
      @(negedge clk);
      if (!hold && pq.size() > 0) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = pq.pop_front();
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'h0;
      end
      rst            = 1'b0;
      imem_req_ready = rr;
      redirect_valid = rv;
      redirect_pc    = rp;
      instr_ready    = ir;
      #1;
      if (imem_req_valid && imem_req_ready) begin
         pq.push_back(mem_word(imem_req_addr));
         $display("t=%0t REQ addr=%h", $time, imem_req_addr);
      end
      if (instr_valid && instr_ready && !redirect_valid)
         $display("t=%0t POP pc=%h instr=%h", $time, instr_pc, instruction);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst            = 1'b1;
      hold           = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      instr_ready    = 1'b0;
      pq.delete();
      #1;
      check({tag, "_rst_req_valid"}, 32'(imem_req_valid), 32'd0);
      check({tag, "_rst_instr_valid"}, 32'(instr_valid), 32'd0);
      check({tag, "_rst_instruction"}, instruction, 32'h0);
      check({tag, "_rst_instr_pc"}, instr_pc, 32'h0);
      check({tag, "_rst_fault"}, 32'(fetch_fault), 32'd0);
   endtask

   initial begin
      rst            = 1'b1;
      hold           = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      instr_ready    = 1'b0;

      // Streaming from reset with a single-cycle memory
      do_reset("t1");
      cyc(1, 0, 0, 1);
      check("t1_c1_req_valid", 32'(imem_req_valid), 32'd1);
      check("t1_c1_addr", imem_req_addr, 32'h0);
      cyc(1, 0, 0, 1);
      check("t1_c2_addr", imem_req_addr, 32'h4);
      check("t1_c2_instr_valid", 32'(instr_valid), 32'd0);
      cyc(1, 0, 0, 1);
      check("t1_c3_instr_valid", 32'(instr_valid), 32'd1);
      check("t1_c3_pc", instr_pc, 32'h0);
      check("t1_c3_word", instruction, mem_word(32'h0));
      check("t1_c3_addr", imem_req_addr, 32'h8);
      cyc(1, 0, 0, 1);
      check("t1_c4_pc", instr_pc, 32'h4);
      cyc(1, 0, 0, 1);
      check("t1_c5_pc", instr_pc, 32'h8);
      check("t1_c5_word", instruction, mem_word(32'h8));

      // Consumer stalled: FIFO fills to DEPTH, requests stop, then drains in order
      do_reset("t2");
      for (int i = 0; i < 10; i++)
         cyc(1, 0, 0, 0);
      check("t2_full_req_valid", 32'(imem_req_valid), 32'd0);
      check("t2_full_instr_valid", 32'(instr_valid), 32'd1);
      check("t2_full_pc", instr_pc, 32'h0);
      cyc(1, 0, 0, 1);
      check("t2_c11_req_valid", 32'(imem_req_valid), 32'd0);
      check("t2_c11_pc", instr_pc, 32'h0);
      for (int i = 1; i < 6; i++) begin
         cyc(1, 0, 0, 1);
         check("t2_drain_valid", 32'(instr_valid), 32'd1);
         check("t2_drain_pc", instr_pc, 32'(i * 4));
         if (i == 1) begin
            check("t2_c12_req_valid", 32'(imem_req_valid), 32'd1);
            check("t2_c12_addr", imem_req_addr, 32'h10);
         end
      end

      // Redirect with two requests in flight: both stale words dropped
      do_reset("t3");
      hold = 1'b1;
      cyc(1, 0, 0, 1);
      cyc(1, 0, 0, 1);
      check("t3_c2_addr", imem_req_addr, 32'h4);
      cyc(1, 1, 32'h100, 1);
      check("t3_redir_req_valid", 32'(imem_req_valid), 32'd0);
      hold = 1'b0;
      cyc(1, 0, 0, 1);
      check("t3_c4_req_valid", 32'(imem_req_valid), 32'd0);
      check("t3_c4_instr_valid", 32'(instr_valid), 32'd0);
      cyc(1, 0, 0, 1);
      check("t3_c5_instr_valid", 32'(instr_valid), 32'd0);
      check("t3_c5_req_valid", 32'(imem_req_valid), 32'd1);
      check("t3_c5_addr", imem_req_addr, 32'h100);
      cyc(1, 0, 0, 1);
      check("t3_c6_instr_valid", 32'(instr_valid), 32'd0);
      check("t3_c6_addr", imem_req_addr, 32'h104);
      cyc(1, 0, 0, 1);
      check("t3_c7_pc", instr_pc, 32'h100);
      check("t3_c7_word", instruction, mem_word(32'h100));
      cyc(1, 0, 0, 1);
      check("t3_c8_pc", instr_pc, 32'h104);

      // Redirect coinciding with a response and a pop
      do_reset("t4");
      cyc(1, 0, 0, 1);
      cyc(1, 0, 0, 1);
      cyc(1, 0, 0, 1);
      check("t4_c3_pc", instr_pc, 32'h0);
      cyc(1, 1, 32'h200, 1);
      check("t4_redir_req_valid", 32'(imem_req_valid), 32'd0);
      cyc(1, 0, 0, 1);
      check("t4_c5_instr_valid", 32'(instr_valid), 32'd0);
      check("t4_c5_req_valid", 32'(imem_req_valid), 32'd1);
      check("t4_c5_addr", imem_req_addr, 32'h200);
      cyc(1, 0, 0, 1);
      check("t4_c6_instr_valid", 32'(instr_valid), 32'd0);
      cyc(1, 0, 0, 1);
      check("t4_c7_pc", instr_pc, 32'h200);
      check("t4_c7_word", instruction, mem_word(32'h200));
      cyc(1, 0, 0, 1);
      check("t4_c8_pc", instr_pc, 32'h204);

      // Memory not ready: request held stable, issued exactly once
      do_reset("t5");
      for (int i = 0; i < 5; i++) begin
         cyc(0, 0, 0, 1);
         check("t5_wait_req_valid", 32'(imem_req_valid), 32'd1);
         check("t5_wait_addr", imem_req_addr, 32'h0);
      end
      cyc(1, 0, 0, 1);
      check("t5_accept_addr", imem_req_addr, 32'h0);
      cyc(1, 0, 0, 1);
      check("t5_c7_addr", imem_req_addr, 32'h4);
      check("t5_c7_instr_valid", 32'(instr_valid), 32'd0);
      cyc(1, 0, 0, 1);
      check("t5_c8_pc", instr_pc, 32'h0);
      cyc(1, 0, 0, 1);
      check("t5_c9_pc", instr_pc, 32'h4);

      // Misaligned redirect target
      do_reset("t6");
      cyc(1, 0, 0, 1);
      cyc(1, 1, 32'h102, 1);
      check("t6_redir_req_valid", 32'(imem_req_valid), 32'd0);
      cyc(1, 0, 0, 1);
`ifdef FETCH_ALIGN_CHECK_EN
      check("t6_c3_fault", 32'(fetch_fault), 32'd1);
      check("t6_c3_req_valid", 32'(imem_req_valid), 32'd0);
      check("t6_c3_instr_valid", 32'(instr_valid), 32'd0);
      cyc(1, 0, 0, 1);
      check("t6_c4_fault", 32'(fetch_fault), 32'd1);
      check("t6_c4_req_valid", 32'(imem_req_valid), 32'd0);
      cyc(1, 1, 32'h200, 1);
      check("t6_c5_req_valid", 32'(imem_req_valid), 32'd0);
      cyc(1, 0, 0, 1);
      check("t6_c6_fault", 32'(fetch_fault), 32'd0);
      check("t6_c6_req_valid", 32'(imem_req_valid), 32'd1);
      check("t6_c6_addr", imem_req_addr, 32'h200);
      cyc(1, 0, 0, 1);
      cyc(1, 0, 0, 1);
      check("t6_c8_pc", instr_pc, 32'h200);
`else
      check("t6_c3_fault", 32'(fetch_fault), 32'd0);
      check("t6_c3_req_valid", 32'(imem_req_valid), 32'd1);
      check("t6_c3_addr", imem_req_addr, 32'h100);
      cyc(1, 0, 0, 1);
      cyc(1, 0, 0, 1);
      check("t6_c5_pc", instr_pc, 32'h100);
      check("t6_c5_word", instruction, mem_word(32'h100));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
